pending_encoder: RTL and testbench
==================================

# pending_encoder

Registered, handshaked priority encoder that is the counterpart of the team's 2-to-4 one-hot decoder. It captures N one-hot request lines into a sticky pending register and emits the binary index of the highest-priority pending request, one index per valid/ready transfer. Each index clears its pending bit when it is accepted. It sits on the request side of an interrupt/event path and feeds index consumers such as the decoder.

## Interface
- `N`, default 4: number of request lines; legal values ≥ 2.
- `W`, localparam `$clog2(N)`: index width, 2 at default.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N: request lines, sampled every cycle; level or pulse.
- `en`  in  1: capture enable; gates only the capture of `req`.
- `clr_overrun`  in  1: clears all `overrun` bits.
- `out_ready`  in  1: consumer accepts `out_idx`.
- `out_valid`  out  1: `out_idx` holds a pending request.
- `out_idx`  out  W: binary index of the presented request.
- `pending`  out  N: registered pending vector.
- `overrun`  out  N: sticky flag, set when a request hits an already-pending bit.

## Operation
- Reset values: `pending`=0, `overrun`=0, `out_valid`=0, `out_idx`=0, FSM in IDLE.
- While `rst`=1, `req` is ignored.
- Handshake: a transfer occurs in a cycle with `out_valid & out_ready`. `ack` = onehot(`out_idx`) when a transfer occurs, else 0.
- Pending update: `pending` <= (`pending` & ~`ack`) | (`req` & {N{`en`}}).
- If `ack` and `req` hit the same bit in one cycle, the new request wins. The bit stays set and no overrun is flagged.
- Overrun: `overrun[i]` is set when `en` & `req[i]` & `pending[i]` & ~`ack[i]`.
- `clr_overrun` clears all bits. If a set event and `clr_overrun` occur in the same cycle, the set wins for that bit.
- Priority: the lowest index wins.
- FSM states:
  - IDLE: `out_valid`=0. If `pending`≠0, load `out_idx` = prio(`pending`) and go to PRESENT. Otherwise stay.
  - PRESENT: `out_valid`=1 and `out_idx` is held stable while `out_ready`=0.
  - On a transfer, let rem = `pending` & ~`ack`. If rem≠0, load `out_idx` = prio(rem) and stay in PRESENT. Otherwise go to IDLE.
- rem uses the registered `pending` only. Requests captured in the same cycle are considered one cycle later.
- `out_idx` holds its last value in IDLE.
- `en`=0 blocks capture only. Already-pending requests still drain.
- An in-flight `out_idx` is never replaced by a newly arrived higher-priority request. Priority is evaluated only in IDLE or on a transfer.

## Timing
- Capture latency: `req` sampled at edge k appears in `pending` after edge k.
- Output latency: `out_valid` rises after edge k+1, so request-to-valid is 2 cycles.
- Throughput: one index per cycle while `out_ready`=1 and requests remain pending. There are no bubbles between back-to-back transfers.
- Outputs are registered; there is no combinational path from input to output.
- Reset mid-operation: all state returns to reset values after the reset edge, and any in-flight index is dropped.

## Structure
- Shared package `pending_encoder_pkg`:
  - state enum `enc_state_t` {IDLE, PRESENT};
  - function `onehot(idx, N)`.
- Sub-module `priority_encoder`: combinational, N→W index plus an `any` flag, lowest index wins. It is instantiated twice, once for prio(`pending`) and once for prio(rem).
- Top module holds the pending/overrun registers, the FSM and the output registers.

## Test plan
All scenarios use N=4.
- **Single request:** after reset, `req`=0100 for 1 cycle with `out_ready`=1. Required: `out_valid`=1 with `out_idx`=2 exactly 2 cycles after the request, for 1 cycle; then `pending`=0000 and `out_valid`=0.
- **Back-to-back drain:** `req`=1011 for 1 cycle with `out_ready`=1. Required: `out_idx`=0, 1, 3 on consecutive cycles with `out_valid`=1, then `out_valid`=0.
- **Backpressure:** `req`=0010 with `out_ready`=0 for 5 cycles, and `req`=0001 arriving during that hold. Required: `out_idx`=1 held stable throughout; after `out_ready`=1, transfers are idx 1 then idx 0.
- **Overrun and collisions:**
  - `req`=0100 twice with `out_ready`=0 → `overrun`=0100.
  - `clr_overrun` in the same cycle as a third `req[2]` → `overrun` remains 0100.
  - `req[2]` in the same cycle as the idx-2 transfer → `pending[2]` remains 1 and `overrun` is unchanged.
- **Enable gating:**
  - `en`=0 with `req`=1111 → `pending` stays 0000.
  - With `pending`=0110 and `en`=0 → idx 1 then idx 2 are still delivered.
- **Reset mid-presentation:** `rst`=1 while `out_valid`=1 and `pending`=1010, with `req`=0001 asserted during reset. Required: next cycle all outputs are 0, and nothing is captured from that `req`.

Source files
------------

// File: rtl/pending_encoder_pkg.sv
// Shared types and helpers for the pending-request priority encoder.
package pending_encoder_pkg;

    localparam int MAX_N = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } enc_state_t;

    // Returns an all-zero vector when idx is outside 0..n-1.
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        onehot = '0;
        if (idx >= 0 && idx < n)
            onehot = {{(MAX_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/pending_encoder_if.sv
// Valid/ready index stream from the encoder to an index consumer.
interface pending_encoder_if #(parameter int W = 2);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;

    modport master (output out_valid, output out_idx, input  out_ready);
    modport slave  (input  out_valid, input  out_idx, output out_ready);
endinterface

// File: rtl/pending_encoder_priority.sv
// Combinational N-to-W priority encoder; the lowest set index wins.
module priority_encoder #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);
    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pending_encoder.sv
// Sticky pending register, overrun flags and a two-state presenter that
// hands out one request index per valid/ready transfer.
//
//   state   | meaning
//   IDLE    | nothing presented; loads prio(pending) when any bit is set
//   PRESENT | out_idx held until accepted, then reloads from the remainder
module pending_encoder
    import pending_encoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic                en,
    input  logic                clr_overrun,
    output logic [N-1:0]        pending,
    output logic [N-1:0]        overrun,
    pending_encoder_if.master   ob
);
    localparam int W = $clog2(N);
    localparam logic [0:0] ST_IDLE    = IDLE;
    localparam logic [0:0] ST_PRESENT = PRESENT;

    logic [0:0]   state;
    logic         out_valid_q;
    logic [W-1:0] out_idx_q;

    logic         xfer;
    logic [N-1:0] ack, rem, cap;
    logic [N-1:0] pending_nxt, overrun_nxt, ovr_set;
    logic [W-1:0] pend_idx, rem_idx;
    logic         pend_any, rem_any;

    assign xfer = out_valid_q & ob.out_ready;
    assign ack  = xfer ? N'(onehot(32'(out_idx_q), N)) : '0;
    assign rem  = pending & ~ack;
    assign cap  = req & {N{en}};

    // A fresh request on the bit being acknowledged keeps it pending without overrun.
    assign pending_nxt = rem | cap;
    assign ovr_set     = cap & pending & ~ack;
    assign overrun_nxt = (clr_overrun ? '0 : overrun) | ovr_set;

    priority_encoder #(.N(N), .W(W)) u_prio_pend (
        .vec (pending),
        .idx (pend_idx),
        .any (pend_any)
    );

    priority_encoder #(.N(N), .W(W)) u_prio_rem (
        .vec (rem),
        .idx (rem_idx),
        .any (rem_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pending     <= '0;
            overrun     <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            if (state == ST_IDLE) begin
                if (pend_any) begin
                    out_idx_q   <= pend_idx;
                    out_valid_q <= 1'b1;
                    state       <= ST_PRESENT;
                end
            end else if (xfer) begin
                if (rem_any) begin
                    out_idx_q <= rem_idx;
                end else begin
                    out_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            end
        end
    end

    assign ob.out_valid = out_valid_q;
    assign ob.out_idx   = out_idx_q;
endmodule

// File: tb/tb_pending_encoder.sv
// Directed-vector bench for pending_encoder at N=4.
module tb_pending_encoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       en;
    logic       clr_overrun;
    logic [3:0] pending;
    logic [3:0] overrun;

    int n_cmp = 0;
    int n_bad = 0;

    pending_encoder_if #(.W(2)) ob ();

    pending_encoder #(.N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .en          (en),
        .clr_overrun (clr_overrun),
        .pending     (pending),
        .overrun     (overrun),
        .ob          (ob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] idx);
        chk({tag, ".valid"}, 32'(ob.out_valid), 32'(v));
        if (v) chk({tag, ".idx"}, 32'(ob.out_idx), 32'(idx));
    endtask

    initial begin
        rst = 1'b1; req = '0; en = 1'b1; clr_overrun = 1'b0; ob.out_ready = 1'b0;
        tick(); tick();
        chk("rst.valid",   32'(ob.out_valid), 32'd0);
        chk("rst.idx",     32'(ob.out_idx),   32'd0);
        chk("rst.pending", 32'(pending),      32'd0);
        chk("rst.overrun", 32'(overrun),      32'd0);
        rst = 1'b0;
        tick();

        // single request, two-cycle latency
        ob.out_ready = 1'b1; req = 4'b0100;
        tick();
        req = '0;
        chk("single.pend", 32'(pending), 32'h4);
        chk_out("single.c1", 1'b0, 2'd0);
        tick();
        chk_out("single.c2", 1'b1, 2'd2);
        tick();
        chk_out("single.c3", 1'b0, 2'd0);
        chk("single.pend0", 32'(pending), 32'h0);

        // back-to-back drain with no bubbles
        req = 4'b1011;
        tick();
        req = '0;
        tick(); chk_out("b2b.0", 1'b1, 2'd0);
        tick(); chk_out("b2b.1", 1'b1, 2'd1);
        tick(); chk_out("b2b.3", 1'b1, 2'd3);
        tick(); chk_out("b2b.end", 1'b0, 2'd0);

        // backpressure: idx 1 stays put even after req[0] arrives
        ob.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req = (i == 2) ? 4'b0011 : 4'b0010;
            tick();
            if (i >= 1) chk_out("bp.hold", 1'b1, 2'd1);
        end
        req = '0;
        chk("bp.pend", 32'(pending), 32'h3);
        ob.out_ready = 1'b1;
        tick(); chk_out("bp.x0", 1'b1, 2'd0);
        tick(); chk_out("bp.end", 1'b0, 2'd0);
        chk("bp.ovr", 32'(overrun), 32'h2);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("bp.clr", 32'(overrun), 32'h0);

        // overrun, clear-vs-set, ack-vs-request collision
        ob.out_ready = 1'b0; req = 4'b0100;
        tick();
        chk("ovr.first", 32'(overrun), 32'h0);
        tick();
        chk("ovr.second", 32'(overrun), 32'h4);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr.setwins", 32'(overrun), 32'h4);
        chk_out("ovr.present", 1'b1, 2'd2);
        ob.out_ready = 1'b1;
        tick();
        req = '0;
        chk("coll.pend", 32'(pending), 32'h4);
        chk("coll.ovr",  32'(overrun), 32'h4);
        chk_out("coll.idle", 1'b0, 2'd0);
        tick(); chk_out("coll.again", 1'b1, 2'd2);
        tick(); chk_out("coll.end", 1'b0, 2'd0);
        chk("coll.pend0", 32'(pending), 32'h0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("coll.clr", 32'(overrun), 32'h0);

        // enable gating
        en = 1'b0; req = 4'b1111;
        tick(); tick();
        chk("en.pend", 32'(pending), 32'h0);
        chk_out("en.none", 1'b0, 2'd0);
        ob.out_ready = 1'b0; en = 1'b1; req = 4'b0110;
        tick();
        en = 1'b0; req = 4'b1111;
        chk("en.load", 32'(pending), 32'h6);
        tick(); chk_out("en.d1", 1'b1, 2'd1);
        ob.out_ready = 1'b1;
        tick(); chk_out("en.d2", 1'b1, 2'd2);
        tick(); chk_out("en.end", 1'b0, 2'd0);
        chk("en.pend0", 32'(pending), 32'h0);
        chk("en.ovr", 32'(overrun), 32'h0);
        en = 1'b1; req = '0;

        // reset while presenting
        ob.out_ready = 1'b0; req = 4'b1010;
        tick();
        req = '0;
        tick(); chk_out("mrst.pre", 1'b1, 2'd1);
        chk("mrst.prepend", 32'(pending), 32'hA);
        rst = 1'b1; req = 4'b0001;
        tick();
        chk("mrst.valid",   32'(ob.out_valid), 32'd0);
        chk("mrst.idx",     32'(ob.out_idx),   32'd0);
        chk("mrst.pending", 32'(pending),      32'd0);
        chk("mrst.overrun", 32'(overrun),      32'd0);
        rst = 1'b0; req = '0;
        tick();
        chk("mrst.nocap", 32'(pending), 32'h0);
        tick();
        chk_out("mrst.quiet", 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
